breath_mode_ctrl: RTL and testbench
===================================

Name: breath_mode_ctrl

Overview:
Upstream control stage for the breathing-LED generator. It synchronises and debounces one push-button and distinguishes short presses from long presses. It maintains a 2-bit lighting mode and drives the registered control strobes that gate and pace the breath generator: enable, speed select and force-on. A short press advances OFF -> SLOW -> FAST -> ON -> OFF. A long press forces OFF.

Parameters:
CNT_DB_MAX, 20'd999_999, debounce window in sys_clk cycles (20 ms at 50 MHz); press and release both use it
CNT_HOLD_MAX, 26'd49_999_999, held cycles after press is accepted before long press fires (1 s at 50 MHz)

Ports:
sys_clk  input  1  system clock, all logic on rising edge
sys_rst  input  1  reset; one clock; reset is asynchronous and active-high
key_in  input  1  raw button, active-low (0 = pressed), asynchronous to sys_clk
mode  output  2  current mode: 0 OFF, 1 SLOW, 2 FAST, 3 ON
breath_en  output  1  high in SLOW or FAST
speed_sel  output  1  high in FAST only
led_force_on  output  1  high in ON only
key_flag  output  1  one-cycle pulse when a press is accepted

Behaviour:
- Reset (async assert, sync release): synchroniser flops = 1, key FSM = K_IDLE, counters = 0, mode = OFF, all outputs 0.
- Synchroniser: key_in passes through 2 flops. key_s is the second stage. All FSM decisions use key_s only.
- Key FSM:
  - K_IDLE: on key_s == 0 go to K_PDB with cnt_db = 0.
  - K_PDB: while key_s == 0, cnt_db increments. If key_s == 1 (bounce), return to K_IDLE; no event.
  - K_PDB exit: when cnt_db == CNT_DB_MAX-1 with key_s == 0, go to K_HELD, clear cnt_hold and pulse key_flag on the next cycle.
  - K_HELD: while key_s == 0, cnt_hold increments.
  - K_HELD long press: when cnt_hold == CNT_HOLD_MAX-1, go to K_LONG and set mode to OFF.
  - K_HELD release: on key_s == 1, go to K_RDB with short = 1 and cnt_db = 0.
  - K_LONG: on key_s == 1, go to K_RDB with short = 0 and cnt_db = 0.
  - K_RDB: while key_s == 1, cnt_db increments.
  - K_RDB re-press: on key_s == 0, return to K_HELD if short, else K_LONG. cnt_hold is preserved, not reset.
  - K_RDB exit: when cnt_db == CNT_DB_MAX-1, go to K_IDLE. If short, mode advances by 1 (mod 4, 3 wraps to 0).
- Mode changes only on a short-press release or a long-press fire. It never changes on the press edge itself.
- Latency:
  - key_flag rises exactly CNT_DB_MAX+1 cycles after key_s first goes low in a clean press.
  - The mode update and its decoded outputs are visible 1 cycle after the terminating cycle.
- Output decode: breath_en, speed_sel and led_force_on are registered from next-mode, so they change in the same cycle as mode. They are mutually consistent at all times.
- Boundaries:
  - Long press while already OFF: mode stays OFF; K_LONG still entered; release causes no advance.
  - cnt_hold saturates in K_LONG (no wrap, no second long event).
  - Bounce shorter than CNT_DB_MAX during release is absorbed; no extra advance.
  - Reset mid-press: FSM returns to K_IDLE. A key still held after reset needs a full new debounce.
- Widths: cnt_db 20 bits, cnt_hold 26 bits; the parameters must fit them. Counters compare with ==, never >.

Decomposition:
- Shared package breath_pkg holds:
  - mode encodings: MODE_OFF=2'd0, MODE_SLOW=2'd1, MODE_FAST=2'd2, MODE_ON=2'd3;
  - key FSM state encodings K_IDLE, K_PDB, K_HELD, K_LONG, K_RDB (3 bits, binary).
- One sub-module is natural: key_sync (2-flop synchroniser, reset value 1). The FSM, counters and mode register stay in the top.

Test Plan:
Bench parameters: CNT_DB_MAX=4, CNT_HOLD_MAX=20; 20 ns clock.
1. Reset held then released, key_in=1 -> mode=0; breath_en, speed_sel, led_force_on and key_flag all 0 for 100 cycles.
2. Clean press for 8 cycles then release for 8 cycles -> key_flag one pulse 5 cycles after key_s falls. After the release window: mode=1, breath_en=1, speed_sel=0.
3. Four clean short presses -> mode sequence 1, 2, 3, 0. speed_sel=1 only at mode 2; led_force_on=1 only at mode 3; breath_en=0 at 0 and 3.
4. Press glitch of 2 cycles low, then high -> no key_flag, mode unchanged. Release glitch of 2 cycles high in a short press -> exactly one mode advance.
5. From mode 2, hold key for 30 cycles -> key_flag once, mode=0 about 20 cycles after acceptance. Subsequent release gives no advance; mode stays 0.
6. Assert sys_rst during K_HELD at mode 2 with key held low -> mode=0 asynchronously. After release of reset with key still low, key_flag fires only after a fresh 4-cycle debounce.

Source files
------------

// File: rtl/breath_pkg.sv
// rtl/breath_pkg.sv - shared mode and key-FSM encodings for the breathing-LED control stage
package breath_pkg;

    typedef enum logic [1:0] {
        MODE_OFF  = 2'd0,
        MODE_SLOW = 2'd1,
        MODE_FAST = 2'd2,
        MODE_ON   = 2'd3
    } mode_t;

    typedef enum logic [2:0] {
        K_IDLE = 3'd0,
        K_PDB  = 3'd1,
        K_HELD = 3'd2,
        K_LONG = 3'd3,
        K_RDB  = 3'd4
    } key_state_t;

    // Short-press sequence: OFF -> SLOW -> FAST -> ON -> OFF
    function automatic mode_t next_mode(input mode_t m);
        return mode_t'(m + 2'd1);
    endfunction

endpackage

// File: rtl/key_sync.sv
// rtl/key_sync.sv - two-flop synchroniser for the raw push-button, idles high
module key_sync (
    input  logic sys_clk,
    input  logic sys_rst,
    input  logic din,
    output logic dout
);

    logic meta;

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            meta <= 1'b1;
            dout <= 1'b1;
        end else begin
            meta <= din;
            dout <= meta;
        end
    end

endmodule

// File: rtl/breath_mode_ctrl.sv
// rtl/breath_mode_ctrl.sv - debounced short/long press detection and lighting-mode register
module breath_mode_ctrl
    import breath_pkg::*;
#(
    parameter logic [19:0] CNT_DB_MAX   = 20'd999_999,
    parameter logic [25:0] CNT_HOLD_MAX = 26'd49_999_999
) (
    input  logic       sys_clk,
    input  logic       sys_rst,
    input  logic       key_in,
    output logic [1:0] mode,
    output logic       breath_en,
    output logic       speed_sel,
    output logic       led_force_on,
    output logic       key_flag
);

    localparam logic [19:0] DB_LAST   = CNT_DB_MAX - 20'd1;
    localparam logic [25:0] HOLD_LAST = CNT_HOLD_MAX - 26'd1;

    logic        key_s;
    key_state_t  state, state_nxt;
    logic [19:0] cnt_db, cnt_db_nxt;
    logic [25:0] cnt_hold, cnt_hold_nxt;
    logic        short_q, short_nxt;
    mode_t       mode_q, mode_nxt;
    logic        flag_nxt;

    key_sync u_key_sync (
        .sys_clk (sys_clk),
        .sys_rst (sys_rst),
        .din     (key_in),
        .dout    (key_s)
    );

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state        <= K_IDLE;
            cnt_db       <= '0;
            cnt_hold     <= '0;
            short_q      <= 1'b0;
            mode_q       <= MODE_OFF;
            key_flag     <= 1'b0;
            breath_en    <= 1'b0;
            speed_sel    <= 1'b0;
            led_force_on <= 1'b0;
        end else begin
            state        <= state_nxt;
            cnt_db       <= cnt_db_nxt;
            cnt_hold     <= cnt_hold_nxt;
            short_q      <= short_nxt;
            mode_q       <= mode_nxt;
            key_flag     <= flag_nxt;
            // Decoded from next-mode so the strobes move in step with mode
            breath_en    <= (mode_nxt == MODE_SLOW) || (mode_nxt == MODE_FAST);
            speed_sel    <= (mode_nxt == MODE_FAST);
            led_force_on <= (mode_nxt == MODE_ON);
        end
    end

    always_comb begin
        state_nxt    = state;
        cnt_db_nxt   = cnt_db;
        cnt_hold_nxt = cnt_hold;
        short_nxt    = short_q;
        mode_nxt     = mode_q;
        flag_nxt     = 1'b0;
        case (state)
            K_IDLE: begin
                if (!key_s) begin
                    state_nxt  = K_PDB;
                    cnt_db_nxt = '0;
                end
            end
            K_PDB: begin
                if (key_s) begin
                    state_nxt = K_IDLE;
                end else if (cnt_db == DB_LAST) begin
                    state_nxt    = K_HELD;
                    cnt_hold_nxt = '0;
                    flag_nxt     = 1'b1;
                end else begin
                    cnt_db_nxt = cnt_db + 20'd1;
                end
            end
            K_HELD: begin
                if (key_s) begin
                    state_nxt  = K_RDB;
                    short_nxt  = 1'b1;
                    cnt_db_nxt = '0;
                end else if (cnt_hold == HOLD_LAST) begin
                    state_nxt = K_LONG;
                    mode_nxt  = MODE_OFF;
                end else begin
                    cnt_hold_nxt = cnt_hold + 26'd1;
                end
            end
            K_LONG: begin
                // cnt_hold stays parked at its terminal value: one long event per press
                if (key_s) begin
                    state_nxt  = K_RDB;
                    short_nxt  = 1'b0;
                    cnt_db_nxt = '0;
                end
            end
            K_RDB: begin
                if (!key_s) begin
                    state_nxt = short_q ? K_HELD : K_LONG;
                end else if (cnt_db == DB_LAST) begin
                    state_nxt = K_IDLE;
                    if (short_q) begin
                        mode_nxt = next_mode(mode_q);
                    end
                end else begin
                    cnt_db_nxt = cnt_db + 20'd1;
                end
            end
            default: begin
                state_nxt = K_IDLE;
            end
        endcase
    end

    assign mode = mode_q;

endmodule

// File: tb/tb_breath_mode_ctrl.sv
// tb/tb_breath_mode_ctrl.sv - self-checking bench for breath_mode_ctrl against a run-length press model
module tb_breath_mode_ctrl;

    localparam int DB   = 4;
    localparam int HOLD = 20;

    logic       sys_clk = 1'b0;
    logic       sys_rst;
    logic       key_in;
    logic [1:0] mode;
    logic       breath_en;
    logic       speed_sel;
    logic       led_force_on;
    logic       key_flag;

    int total = 0;
    int bad   = 0;

    breath_mode_ctrl #(
        .CNT_DB_MAX   (20'd4),
        .CNT_HOLD_MAX (26'd20)
    ) dut (
        .sys_clk      (sys_clk),
        .sys_rst      (sys_rst),
        .key_in       (key_in),
        .mode         (mode),
        .breath_en    (breath_en),
        .speed_sel    (speed_sel),
        .led_force_on (led_force_on),
        .key_flag     (key_flag)
    );

    always #10 sys_clk = ~sys_clk;

    // Reference: button seen two clocks late; a press is a run of DB+1 low samples,
    // a release a run of DB+1 high samples; long press after HOLD held-low samples.
    logic m_q1, m_q2;
    int   m_low_run, m_high_run, m_held, m_mode;
    bit   m_acc, m_long, m_flag;

    task automatic model_reset();
        m_q1 = 1'b1; m_q2 = 1'b1;
        m_low_run = 0; m_high_run = 0; m_held = 0; m_mode = 0;
        m_acc = 0; m_long = 0; m_flag = 0;
    endtask

    task automatic model_step();
        logic ks;
        if (sys_rst) begin
            model_reset();
            return;
        end
        ks = m_q2;
        m_q2 = m_q1;
        m_q1 = key_in;
        m_flag = 0;
        if (!m_acc) begin
            if (ks == 1'b0) begin
                m_low_run++;
                if (m_low_run == DB + 1) begin
                    m_acc = 1; m_flag = 1; m_held = 0; m_long = 0; m_high_run = 0;
                end
            end else begin
                m_low_run = 0;
            end
        end else if (ks == 1'b1) begin
            m_high_run++;
            if (m_high_run == DB + 1) begin
                m_acc = 0;
                m_low_run = 0;
                if (!m_long) m_mode = (m_mode + 1) % 4;
            end
        end else if (m_high_run != 0) begin
            m_high_run = 0;
        end else if (!m_long) begin
            m_held++;
            if (m_held == HOLD) begin
                m_long = 1;
                m_mode = 0;
            end
        end
    endtask

    function automatic logic [5:0] exp_vec();
        logic [1:0] mm;
        mm = m_mode[1:0];
        return {mm, (m_mode == 1) || (m_mode == 2), m_mode == 2, m_mode == 3, m_flag};
    endfunction

    // Called at a negedge; returns at the following negedge with the model advanced.
    task automatic tick(input logic k);
        key_in = k;
        @(posedge sys_clk);
        model_step();
        @(negedge sys_clk);
    endtask

    task automatic do_reset();
        sys_rst = 1'b1;
        model_reset();
        tick(1'b1);
        tick(1'b1);
        sys_rst = 1'b0;
    endtask

    task automatic test_reset();
        key_in = 1'b1;
        do_reset();
        for (int i = 0; i < 100; i++) begin
            tick(1'b1);
            total++;
            if ({mode, breath_en, speed_sel, led_force_on, key_flag} !== 6'b0) begin
                bad++;
                $display("FAIL reset_idle cyc=%0d got=%b want=000000", i,
                         {mode, breath_en, speed_sel, led_force_on, key_flag});
            end
        end
    endtask

    task automatic test_short_press();
        int flag_cnt = 0;
        int flag_at  = -1;
        for (int i = 0; i < 16; i++) begin
            tick(i < 8 ? 1'b0 : 1'b1);
            if (key_flag) begin
                flag_cnt++;
                flag_at = i;
            end
            total++;
            if ({mode, breath_en, speed_sel, led_force_on, key_flag} !== exp_vec()) begin
                bad++;
                $display("FAIL short_cycle cyc=%0d got=%b want=%b", i,
                         {mode, breath_en, speed_sel, led_force_on, key_flag}, exp_vec());
            end
        end
        total++;
        if (flag_cnt != 1 || flag_at != 6) begin
            bad++;
            $display("FAIL short_flag_timing got count=%0d at=%0d want count=1 at=6", flag_cnt, flag_at);
        end
        total++;
        if ({mode, breath_en, speed_sel} !== 4'b0110) begin
            bad++;
            $display("FAIL short_result got=%b want=0110", {mode, breath_en, speed_sel});
        end
    endtask

    task automatic test_mode_cycle();
        logic [4:0] want [4];
        want[0] = 5'b01_1_0_0;
        want[1] = 5'b10_1_1_0;
        want[2] = 5'b11_0_0_1;
        want[3] = 5'b00_0_0_0;
        do_reset();
        for (int p = 0; p < 4; p++) begin
            for (int i = 0; i < 16; i++) begin
                tick(i < 8 ? 1'b0 : 1'b1);
                total++;
                if ({mode, breath_en, speed_sel, led_force_on, key_flag} !== exp_vec()) begin
                    bad++;
                    $display("FAIL cycle_track p=%0d cyc=%0d got=%b want=%b", p, i,
                             {mode, breath_en, speed_sel, led_force_on, key_flag}, exp_vec());
                end
            end
            total++;
            if ({mode, breath_en, speed_sel, led_force_on} !== want[p]) begin
                bad++;
                $display("FAIL mode_seq p=%0d got=%b want=%b", p,
                         {mode, breath_en, speed_sel, led_force_on}, want[p]);
            end
        end
    endtask

    task automatic test_glitch();
        int flag_cnt = 0;
        logic [1:0] start_mode;
        start_mode = mode;
        for (int i = 0; i < 12; i++) begin
            tick(i < 2 ? 1'b0 : 1'b1);
            if (key_flag) flag_cnt++;
        end
        total++;
        if (flag_cnt != 0 || mode !== start_mode) begin
            bad++;
            $display("FAIL press_glitch got flags=%0d mode=%0d want flags=0 mode=%0d",
                     flag_cnt, mode, start_mode);
        end
        flag_cnt = 0;
        for (int i = 0; i < 20; i++) begin
            tick((i < 8 || (i >= 10 && i < 12)) ? 1'b0 : 1'b1);
            if (key_flag) flag_cnt++;
            total++;
            if ({mode, breath_en, speed_sel, led_force_on, key_flag} !== exp_vec()) begin
                bad++;
                $display("FAIL release_glitch_track cyc=%0d got=%b want=%b", i,
                         {mode, breath_en, speed_sel, led_force_on, key_flag}, exp_vec());
            end
        end
        total++;
        if (flag_cnt != 1 || mode !== start_mode + 2'd1) begin
            bad++;
            $display("FAIL release_glitch got flags=%0d mode=%0d want flags=1 mode=%0d",
                     flag_cnt, mode, start_mode + 2'd1);
        end
    endtask

    task automatic test_long_press();
        int flag_cnt = 0;
        // one short press moves SLOW -> FAST
        for (int i = 0; i < 16; i++) tick(i < 8 ? 1'b0 : 1'b1);
        total++;
        if (mode !== 2'd2) begin
            bad++;
            $display("FAIL long_setup got mode=%0d want 2", mode);
        end
        for (int i = 0; i < 40; i++) begin
            tick(i < 30 ? 1'b0 : 1'b1);
            if (key_flag) flag_cnt++;
            if (i == 25) begin
                total++;
                if (mode !== 2'd2) begin
                    bad++;
                    $display("FAIL long_before_fire got mode=%0d want 2", mode);
                end
            end
            if (i == 26) begin
                total++;
                if ({mode, breath_en, speed_sel, led_force_on} !== 5'b0) begin
                    bad++;
                    $display("FAIL long_fire got=%b want=00000",
                             {mode, breath_en, speed_sel, led_force_on});
                end
            end
        end
        total++;
        if (flag_cnt != 1 || mode !== 2'd0) begin
            bad++;
            $display("FAIL long_after_release got flags=%0d mode=%0d want flags=1 mode=0", flag_cnt, mode);
        end
        // long press while already OFF stays OFF
        for (int i = 0; i < 40; i++) begin
            tick(i < 30 ? 1'b0 : 1'b1);
            total++;
            if ({mode, breath_en, speed_sel, led_force_on, key_flag} !== exp_vec()) begin
                bad++;
                $display("FAIL long_from_off cyc=%0d got=%b want=%b", i,
                         {mode, breath_en, speed_sel, led_force_on, key_flag}, exp_vec());
            end
        end
    endtask

    task automatic test_reset_mid_press();
        int flag_at = -1;
        do_reset();
        for (int p = 0; p < 2; p++)
            for (int i = 0; i < 16; i++) tick(i < 8 ? 1'b0 : 1'b1);
        for (int i = 0; i < 10; i++) tick(1'b0);
        total++;
        if (mode !== 2'd2) begin
            bad++;
            $display("FAIL rst_mid_setup got mode=%0d want 2", mode);
        end
        sys_rst = 1'b1;
        model_reset();
        #1;
        total++;
        if ({mode, breath_en, speed_sel, led_force_on, key_flag} !== 6'b0) begin
            bad++;
            $display("FAIL rst_async got=%b want=000000",
                     {mode, breath_en, speed_sel, led_force_on, key_flag});
        end
        @(negedge sys_clk);
        tick(1'b0);
        sys_rst = 1'b0;
        for (int i = 0; i < 20 && flag_at < 0; i++) begin
            tick(1'b0);
            if (key_flag) flag_at = i;
            total++;
            if ({mode, breath_en, speed_sel, led_force_on, key_flag} !== exp_vec()) begin
                bad++;
                $display("FAIL rst_mid_track cyc=%0d got=%b want=%b", i,
                         {mode, breath_en, speed_sel, led_force_on, key_flag}, exp_vec());
            end
        end
        total++;
        if (flag_at != 6) begin
            bad++;
            $display("FAIL rst_mid_debounce got flag_at=%0d want 6", flag_at);
        end
        for (int i = 0; i < 10; i++) tick(1'b1);
    endtask

    task automatic test_random();
        logic lvl = 1'b0;
        int   len;
        for (int r = 0; r < 160; r++) begin
            if (lvl == 1'b0 && $urandom_range(0, 3) == 0)
                len = $urandom_range(20, 40);
            else
                len = $urandom_range(1, 12);
            for (int i = 0; i < len; i++) begin
                tick(lvl);
                total++;
                if ({mode, breath_en, speed_sel, led_force_on, key_flag} !== exp_vec()) begin
                    bad++;
                    $display("FAIL random r=%0d i=%0d got=%b want=%b", r, i,
                             {mode, breath_en, speed_sel, led_force_on, key_flag}, exp_vec());
                end
            end
            lvl = ~lvl;
        end
    endtask

    initial begin
        sys_rst = 1'b1;
        key_in  = 1'b1;
        model_reset();
        @(negedge sys_clk);
        test_reset();
        test_short_press();
        test_mode_cycle();
        test_glitch();
        test_long_press();
        test_reset_mid_press();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
